// File: rtl/spi_master_if.sv
// Host-side and serial-side signals of the single-clock SPI master, bundled
// so the master and its user/slave side connect through one port.
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       ss_n;
  logic       mosi;
  logic       miso;

  modport master (
    input  start, cmd, wdata, miso,
    output busy, done, rdata, rdata_valid, ss_n, mosi
  );

  modport slave (
    output start, cmd, wdata, miso,
    input  busy, done, rdata, rdata_valid, ss_n, mosi
  );
endinterface

// File: rtl/spi_master.sv
// SPI master clocked directly by clk: a command-decode bit, then a 10-bit {cmd,wdata}
// frame, and on read-data frames a latency wait plus an 8-bit receive.
module spi_master #(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic        clk,
  input  logic        rst,
  spi_master_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RECV  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam bit         HAS_WAIT  = (RD_LAT > 0);
  localparam logic [3:0] WAIT_LOAD = 4'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [9:0] shift_reg, shift_next;
  logic [1:0] cmd_reg, cmd_next;
  logic [7:0] rx_reg, rx_next;
  logic [7:0] rdata_reg, rdata_next;
  logic       ss_n_reg, ss_n_next;
  logic       mosi_reg, mosi_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       rvalid_reg, rvalid_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      shift_reg  <= 10'd0;
      cmd_reg    <= 2'd0;
      rx_reg     <= 8'd0;
      rdata_reg  <= 8'd0;
      ss_n_reg   <= 1'b1;
      mosi_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      cmd_reg    <= cmd_next;
      rx_reg     <= rx_next;
      rdata_reg  <= rdata_next;
      ss_n_reg   <= ss_n_next;
      mosi_reg   <= mosi_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      rvalid_reg <= rvalid_next;
    end
  end

  // Every output is registered, so the *_next values describe the cycle that
  // follows the current state, not the current one.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    cmd_next    = cmd_reg;
    rx_next     = rx_reg;
    rdata_next  = rdata_reg;
    ss_n_next   = 1'b1;
    mosi_next   = 1'b0;
    busy_next   = 1'b1;
    done_next   = 1'b0;
    rvalid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        busy_next = 1'b0;
        if (bus.start) begin
          state_next = ST_CMD;
          shift_next = {bus.cmd, bus.wdata};
          cmd_next   = bus.cmd;
          rx_next    = 8'd0;
          ss_n_next  = 1'b0;
          mosi_next  = bus.cmd[1];
          busy_next  = 1'b1;
        end
      end

      ST_CMD: begin
        state_next = ST_SHIFT;
        cnt_next   = 4'd9;
        ss_n_next  = 1'b0;
        mosi_next  = shift_reg[9];
      end

      ST_SHIFT: begin
        ss_n_next = 1'b0;
        if (cnt_reg != 4'd0) begin
          cnt_next   = cnt_reg - 4'd1;
          shift_next = {shift_reg[8:0], 1'b0};
          mosi_next  = shift_reg[8];
        end else if (cmd_reg == 2'b11) begin
          if (HAS_WAIT) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = ST_RECV;
            cnt_next   = 4'd7;
          end
        end else begin
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
          ss_n_next  = 1'b1;
          done_next  = 1'b1;
        end
      end

      ST_WAIT: begin
        ss_n_next = 1'b0;
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = ST_RECV;
          cnt_next   = 4'd7;
        end
      end

      ST_RECV: begin
        ss_n_next = 1'b0;
        rx_next   = {rx_reg[6:0], bus.miso};
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next  = ST_GAP;
          cnt_next    = GAP_LOAD;
          ss_n_next   = 1'b1;
          done_next   = 1'b1;
          rvalid_next = 1'b1;
          rdata_next  = {rx_reg[6:0], bus.miso};
        end
      end

      ST_GAP: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.ss_n        = ss_n_reg;
  assign bus.mosi        = mosi_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.rdata       = rdata_reg;
  assign bus.rdata_valid = rvalid_reg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: scoreboard of expected frames, a bus monitor
// that checks each completed frame, and a behavioural SPI slave with a RAM.
module tb_spi_master;
  localparam int RD_LAT = 2;
  localparam int GAP    = 1;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if bus();

  spi_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_cmp = 0;
  int     n_fail = 0;
  int     exp_done = 0;
  int     done_cnt = 0;
  bit     gap_chk = 1'b0;
  frame_t sb[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(logic [1:0] c, logic [7:0] d, logic [7:0] r);
    frame_t f;
    f.cmd = c;
    f.wdata = d;
    f.rdata = r;
    sb.push_back(f);
    exp_done++;
  endtask

  // ---------------- slave + RAM model ----------------
  logic [7:0] ram [256];
  int         sk = 0;
  logic [9:0] sbits = '0;
  logic [7:0] s_addr = '0;
  logic [7:0] s_byte = '0;
  bit         s_rd = 1'b0;

  always @(negedge clk) begin
    if (rst || bus.ss_n) begin
      sk = 0;
      sbits = '0;
      s_rd = 1'b0;
      bus.miso = 1'b0;
    end else begin
      if (sk >= 1 && sk <= 10) sbits = {sbits[8:0], bus.mosi};
      if (sk == 10) begin
        case (sbits[9:8])
          2'b00: s_addr = sbits[7:0];
          2'b01: ram[s_addr] = sbits[7:0];
          2'b10: s_addr = sbits[7:0];
          default: begin
            s_rd = 1'b1;
            s_byte = ram[s_addr];
          end
        endcase
      end
      if (s_rd && sk >= 11 + RD_LAT && sk <= 18 + RD_LAT)
        bus.miso = s_byte[7 - (sk - 11 - RD_LAT)];
      else
        bus.miso = 1'b0;
      sk++;
    end
  end

  // ---------------- monitor ----------------
  bit          in_frame = 1'b0;
  int          low_len = 0;
  int          hi_len = 0;
  logic [10:0] cap = '0;
  logic        extra = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      low_len = 0;
      hi_len = 0;
    end else if (!bus.ss_n) begin
      if (!in_frame) begin
        if (gap_chk) begin
          check("b2b_gap", 32'(hi_len), 32'(GAP + 1));
          gap_chk = 1'b0;
        end
        in_frame = 1'b1;
        low_len = 0;
        cap = '0;
        extra = 1'b0;
      end
      if (low_len < 11) cap = {cap[9:0], bus.mosi};
      else extra = extra | bus.mosi;
      low_len++;
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        hi_len = 1;
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          frame_t      e;
          logic [10:0] eb;
          bit          rd;
          e = sb.pop_front();
          eb = {e.cmd[1], e.cmd, e.wdata};
          rd = (e.cmd == 2'b11);
          check("ss_n_low_len", 32'(low_len), rd ? 32'(19 + RD_LAT) : 32'd11);
          check("mosi_bits", 32'(cap), 32'(eb));
          check("mosi_tail_zero", 32'(extra), 32'd0);
          check("done_at_end", 32'(bus.done), 32'd1);
          check("rvalid_at_end", 32'(bus.rdata_valid), 32'(rd));
          check("busy_in_gap", 32'(bus.busy), 32'd1);
          if (rd) check("rdata", 32'(bus.rdata), 32'(e.rdata));
          $display("frame cmd=%b wdata=%02h len=%0d mosi=%b rdata_valid=%b rdata=%02h",
                   e.cmd, e.wdata, low_len, cap, bus.rdata_valid, bus.rdata);
        end
      end else begin
        hi_len++;
      end
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_outstanding"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_frame(logic [1:0] c, logic [7:0] d, logic [7:0] r);
    wait_idle("idle_before_start");
    bus.cmd = c;
    bus.wdata = d;
    bus.start = 1'b1;
    push_exp(c, d, r);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.cmd = ~c;
    bus.wdata = ~d;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'hA5] = 8'h3C;
    bus.start = 1'b0;
    bus.cmd = 2'b00;
    bus.wdata = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(bus.ss_n), 32'd1);
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b0;

    // write-address A5, then read-data returning 3C from the slave RAM
    do_frame(2'b00, 8'hA5, 8'h00);
    wait_drain("wr_addr");
    do_frame(2'b11, 8'h00, 8'h3C);
    wait_drain("rd_data");

    // back-to-back with start held high: write-data C3 then read-address 3E
    wait_idle("b2b_idle");
    bus.start = 1'b1;
    bus.cmd = 2'b01;
    bus.wdata = 8'hC3;
    push_exp(2'b01, 8'hC3, 8'h00);
    @(posedge clk);
    #1;
    bus.cmd = 2'b10;
    bus.wdata = 8'h3E;
    push_exp(2'b10, 8'h3E, 8'h00);
    repeat (3) @(negedge clk);
    gap_chk = 1'b1;
    wait_idle("b2b_second");
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_drain("b2b");
    check("b2b_gap_seen", 32'(gap_chk), 32'd0);

    // start pulse mid-SHIFT must be ignored
    do_frame(2'b00, 8'h10, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.cmd = 2'b01;
    bus.wdata = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_drain("busy_start");
    repeat (4) @(negedge clk);
    check("ignored_busy", 32'(bus.busy), 32'd0);
    check("ignored_ss_n", 32'(bus.ss_n), 32'd1);

    // end-to-end through the slave RAM
    do_frame(2'b00, 8'h10, 8'h00);
    do_frame(2'b01, 8'h5A, 8'h00);
    do_frame(2'b10, 8'h10, 8'h00);
    do_frame(2'b11, 8'h00, 8'h5A);
    wait_drain("e2e");

    // reset after four received bits of a read-data frame
    wait_idle("rst_frame_idle");
    bus.cmd = 2'b11;
    bus.wdata = 8'h00;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre_rst_ss_n", 32'(bus.ss_n), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ss_n", 32'(bus.ss_n), 32'd1);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_rvalid", 32'(bus.rdata_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_rdata", 32'(bus.rdata), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_frame(2'b11, 8'h00, 8'h5A);
    wait_drain("post_rst");

    repeat (5) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
